// File: rtl/hs_ifr_word_to_byte_unpacker.sv
// Word-to-byte stream down-converter: 32-bit valid/ready words in, bytes out,
// with partial final words, selectable byte order, frame-end and a byte counter.
module hs_ifr_word_to_byte_unpacker #(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter bit CNT_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic [1:0]  s_bcnt,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        cnt_clr,
    output logic [31:0] cnt_o,
    output logic        busy
);

    typedef enum logic {StIdle, StShift} state_e;

    state_e      state_q;
    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic [1:0]  bcnt_q;
    logic        last_q;
    logic        m_valid_q;
    logic [7:0]  m_data_q;
    logic        m_last_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    logic        handshake;
    logic        final_byte;
    logic        accept;
    logic [1:0]  idx_nxt;

    // Byte k of a word; in big-endian mode the valid bytes sit at the top.
    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [1:0] lane;
        lane = BIG_ENDIAN ? (2'd3 - idx) : idx;
        return word[{lane, 3'b000} +: 8];
    endfunction

    always_comb begin
        handshake  = m_valid_q && m_ready;
        final_byte = (idx_q == bcnt_q);
        idx_nxt    = idx_q + 2'd1;
        // Gated by rst_n so upstream never sees ready while held in reset.
        s_ready    = rst_n && ((state_q == StIdle) || (m_ready && final_byte));
        accept     = s_valid && s_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            word_q    <= 32'd0;
            idx_q     <= 2'd0;
            bcnt_q    <= 2'd0;
            last_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'd0;
            m_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q   <= StShift;
                        word_q    <= s_data;
                        idx_q     <= 2'd0;
                        bcnt_q    <= s_bcnt;
                        last_q    <= s_last;
                        m_valid_q <= 1'b1;
                        m_data_q  <= sel_byte(s_data, 2'd0);
                        m_last_q  <= s_last && (s_bcnt == 2'd0);
                    end
                end
                StShift: begin
                    if (handshake) begin
                        if (!final_byte) begin
                            idx_q    <= idx_nxt;
                            m_data_q <= sel_byte(word_q, idx_nxt);
                            m_last_q <= last_q && (idx_nxt == bcnt_q);
                        end else if (accept) begin
                            // Reload in the final-byte cycle to avoid a bubble.
                            word_q    <= s_data;
                            idx_q     <= 2'd0;
                            bcnt_q    <= s_bcnt;
                            last_q    <= s_last;
                            m_data_q  <= sel_byte(s_data, 2'd0);
                            m_last_q  <= s_last && (s_bcnt == 2'd0);
                        end else begin
                            state_q   <= StIdle;
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!CNT_EN || cnt_clr) begin
            cnt_d = 32'd0;
        end else if (handshake) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = m_valid_q;
    assign cnt_o   = cnt_q;

endmodule

// File: doc/hs_ifr_word_to_byte_unpacker.md
Name: hs_ifr_word_to_byte_unpacker

Overview:
- Stream width down-converter. Accepts 32-bit words (lg_word_t) on a valid/ready slave port and emits them one byte (lg_byte_t) at a time on a valid/ready master port.
- Supports partial final words through a byte count, configurable byte order, and frame-end propagation.
- Sits between word-wide datapaths (bus/DMA side) and byte-serial consumers (UART/SPI/byte FIFOs) in the infra library.
- Also keeps a running byte counter (lg_uint32_t) for statistics.

Parameters:
- BIG_ENDIAN, 0: 0 = byte 0 is s_data[7:0] and goes out first; 1 = byte 0 is s_data[31:24] and goes out first.
- CNT_EN, 1: 1 = byte counter implemented; 0 = cnt_o tied to 0.

Ports:
- clk  input  1  clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  input word valid
- s_ready  output  1  block can accept a word this cycle
- s_data  input  32  input word (lg_word_t)
- s_bcnt  input  2  number of valid bytes minus 1 (0..3 → 1..4 bytes)
- s_last  input  1  word ends a frame
- m_valid  output  1  output byte valid
- m_ready  input  1  downstream accepts byte
- m_data  output  8  output byte (lg_byte_t)
- m_last  output  1  final byte of a frame
- cnt_clr  input  1  synchronous clear of cnt_o
- cnt_o  output  32  bytes transferred on the master port since reset/clear (lg_uint32_t)
- busy  output  1  word held, bytes still pending

Behaviour:
- Reset (rst_n low, async): state=IDLE, m_valid=0, m_data=0, m_last=0, busy=0, cnt_o=0, held word/index/bcnt/last cleared. s_ready=0 while rst_n low. Reset mid-word discards the remaining bytes with no m_last.
- State machine, 2 states:
  - IDLE: s_ready=1. On s_valid&&s_ready, register data/bcnt/last, set idx=0, go to SHIFT. m_valid rises the next cycle (1-cycle latency from accept to first byte).
  - SHIFT: m_valid=1, busy=1, m_data=selected byte idx. A handshake is m_valid&&m_ready.
  - SHIFT, handshake with idx<bcnt: idx+1.
  - SHIFT, handshake with idx==bcnt, no new word: return to IDLE.
- Full throughput: s_ready = (state==IDLE) || (m_ready && idx==bcnt).
  - If a new word is accepted in the same cycle as the final-byte handshake, stay in SHIFT with idx=0. No bubble: 4-byte words sustain 1 byte/cycle, and a 1-byte word can be accepted every cycle.
  - s_ready is combinational from m_ready. No other comb path from slave inputs to master outputs.
- Byte selection, LE (BIG_ENDIAN=0): byte k = s_data[8k+7:8k]. For bcnt<3 the valid bytes are the low bcnt+1 bytes.
- Byte selection, BE (BIG_ENDIAN=1): byte k = s_data[31-8k:24-8k]. For bcnt<3 the valid bytes are the high bcnt+1 bytes. Unused bytes are never emitted.
- m_last = held_last && (idx==bcnt). For a word with s_last=0, m_last stays 0 on all of its bytes.
- m_valid/m_data/m_last are held stable while m_valid&&!m_ready (AXI-stream style; no retraction).
- Counter (CNT_EN=1): cnt_o increments by 1 on each master handshake.
  - Wraps 0xFFFF_FFFF → 0 without a flag.
  - cnt_clr has priority: clr and handshake in the same cycle → cnt_o=0 next cycle.
- s_valid with s_ready=0: no state change. The upstream holds the word; the block never samples s_data then.
- Inputs X while s_valid=0 must not propagate to outputs.

Test Plan:
- Single word, LE: s_data=0x44332211, bcnt=3, last=1, m_ready=1 → bytes 11,22,33,44 on 4 consecutive cycles starting 1 cycle after accept, m_last only on 44, cnt_o=4.
- BE partial: BIG_ENDIAN=1, s_data=0xAABBCCDD, bcnt=1, last=1 → bytes AA,BB only, m_last on BB, next word accepted in the BB handshake cycle.
- Back-to-back throughput: 8 words of bcnt=3 with s_valid and m_ready constantly high → 32 bytes in 32 consecutive cycles, no bubble. Repeat with bcnt=0 words → 1 word/cycle.
- Backpressure: m_ready toggling pseudo-randomly → m_data/m_last stable while stalled, s_ready low until the final-byte handshake, byte sequence matches a reference model.
- Counter: force cnt_o to 0xFFFF_FFFE, transfer 3 bytes → 0xFFFF_FFFF, 0, 1. Assert cnt_clr in the same cycle as a handshake → cnt_o=0.
- Async reset mid-word: assert rst_n=0 after byte 1 of 4 → m_valid, busy, cnt_o drop to 0 immediately (no clock edge). After release, s_ready=1 and the next word is emitted from byte 0.
